// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: direction codes, FSM
// state encoding, default screen bounds and the direction reversal helper.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_UP    = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  localparam int CNT_W     = 22;
  localparam int X_MIN_DEF = 0;
  localparam int X_MAX_DEF = 635;
  localparam int Y_MIN_DEF = 0;
  localparam int Y_MAX_DEF = 475;

  // Opposite heading; NONE (and unused codes) have no opposite.
  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_DOWN:  return DIR_UP;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move tick generator: counts enabled cycles and flags the last cycle of
// each period. move_en is decoded from the count so an async reset drops it
// in the same instant.
module snake_tick_gen
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             move_en
);

  logic [CNT_W-1:0] count;

  assign move_en = enable && (count == period - CNT_W'(1));

  // Count while enabled, wrapping to zero on the move cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (clear)   count <= '0;
    else if (enable)  count <= move_en ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/RUN/CHECK/DEAD FSM, direction qualification,
// length/score tracking and wall/self death decision.
// Optional feature macro SPEEDUP_EN: shorten the step period on each food.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV  = 2500000,
  parameter int MAX_LEN   = 63,
  parameter int X_MIN     = X_MIN_DEF,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_MIN     = Y_MIN_DEF,
  parameter int Y_MAX     = Y_MAX_DEF,
  parameter int TICK_MIN  = 625000,
  parameter int TICK_STEP = 125000
)(
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  dir_req,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  input  logic        food_hit,
  input  logic        self_hit,
  output logic        move_en,
  output logic        body_init,
  output logic [2:0]  dir_out,
  output logic [5:0]  length,
  output logic [7:0]  score,
  output logic        game_over,
  output logic [1:0]  state
);

  // Range checks as offset-from-min <= span; a head below the minimum wraps
  // to a huge offset, so one unsigned compare covers both bounds.
  localparam logic [11:0] X_LO   = 12'(X_MIN);
  localparam logic [11:0] X_SPAN = 12'(X_MAX - X_MIN);
  localparam logic [11:0] Y_LO   = 12'(Y_MIN);
  localparam logic [11:0] Y_SPAN = 12'(Y_MAX - Y_MIN);

  state_t           cur, nxt;
  logic             start_q, start_rise;
  logic             do_init, do_grow, death, dir_ok;
  logic [2:0]       pending_dir;
  logic [11:0]      x_off, y_off;
  logic [CNT_W-1:0] period;

  assign start_rise = start & ~start_q;
  assign x_off      = head_x - X_LO;
  assign y_off      = head_y - Y_LO;
  assign death      = self_hit | (x_off > X_SPAN) | (y_off > Y_SPAN);
  assign dir_ok     = (dir_req != 3'(DIR_NONE)) && (dir_req <= 3'(DIR_UP)) &&
                      !((length > 6'd1) && (dir_req == reverse_of(dir_out)));

  assign state     = cur;
  assign body_init = (cur == ST_IDLE);
  assign game_over = (cur == ST_DEAD);

  // Start edge detector history.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // FSM state register.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) cur <= ST_IDLE;
    else       cur <= nxt;
  end

  // Next state plus init/grow strobes; death outranks food.
  always_comb begin
    nxt     = cur;
    do_init = 1'b0;
    do_grow = 1'b0;
    case (cur)
      ST_IDLE:  if (start_rise) begin nxt = ST_RUN; do_init = 1'b1; end
      ST_RUN:   if (move_en) nxt = ST_CHECK;
      ST_CHECK: begin
        if (death) nxt = ST_DEAD;
        else begin
          nxt     = ST_RUN;
          do_grow = food_hit;
        end
      end
      ST_DEAD:  if (start_rise) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Direction: qualify requests into pending, commit on the move cycle.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      dir_out     <= 3'(DIR_NONE);
      pending_dir <= 3'(DIR_NONE);
    end else if (do_init) begin
      dir_out     <= 3'(DIR_NONE);
      pending_dir <= 3'(DIR_NONE);
    end else if (cur == ST_RUN) begin
      if (move_en) dir_out <= pending_dir;
      if (dir_ok)  pending_dir <= dir_req;
    end
  end

  // Length and score, both saturating.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      length <= 6'd1;
      score  <= 8'd0;
    end else if (do_init) begin
      length <= 6'd1;
      score  <= 8'd0;
    end else if (do_grow) begin
      if (length < 6'(MAX_LEN)) length <= length + 6'd1;
      if (score != 8'hFF)       score  <= score + 8'd1;
    end
  end

`ifdef SPEEDUP_EN
  localparam logic [CNT_W-1:0] P_DIV  = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] P_STEP = CNT_W'(TICK_STEP);

  // Step period shrinks per food down to the floor; restored on each start.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset)        period <= P_DIV;
    else if (do_init) period <= P_DIV;
    else if (do_grow) period <= (period > P_MIN + P_STEP) ? period - P_STEP : P_MIN;
  end
`else
  assign period = CNT_W'(TICK_DIV);
  wire [CNT_W-1:0] unused_speedup = CNT_W'(TICK_MIN) ^ CNT_W'(TICK_STEP);
`endif

  snake_tick_gen u_tick (
    .clk     (VGA_CLK),
    .rst     (reset),
    .enable  (cur == ST_RUN),
    .clear   (cur == ST_IDLE),
    .period  (period),
    .move_en (move_en)
  );

endmodule
